// File: rtl/lbuff_fill_ctrl.sv
// Line-buffer fill controller: fetches one tile row from the frame buffer, unpacks it, writes the inactive line buffer.
// Latency: 7 cycles per frame-buffer word; req at edge 0 -> first write cycle 3, done_o pulse cycle 225.
// Backpressure: none; requests arriving while busy are dropped and flagged on overrun_o.
//
// Ports:
//   clk, rst                    rising-edge clock, async active-high reset
//   line_req_i, row_i           single-cycle fill request and the tile row to fetch
//   fbuff_en_o, fbuff_addr_o    frame-buffer read port (data returns on fbuff_dout_i one cycle later)
//   lbuff_addr_o, lbuff_din_o,
//   lbuff_we_o                  line-buffer write port, one-hot enable selects the buffer being filled
//   rd_sel_o                    buffer the display side reads (always the one not being written)
//   busy_o, done_o              fill in progress / single-cycle completion pulse
//   overrun_o, range_err_o      sticky error flags, cleared only by reset
module lbuff_fill_ctrl #(
  parameter int COLR_PXL_WIDTH   = 12,
  parameter int WIDTH_PX         = 640,
  parameter int TILE_WIDTH       = 4,
  parameter int TILE_PER_LINE    = WIDTH_PX / TILE_WIDTH,
  parameter int TILE_ROWS        = 120,
  parameter int FBUFF_DATA_WIDTH = 60,
  parameter int TILES_PER_WORD   = FBUFF_DATA_WIDTH / COLR_PXL_WIDTH,
  parameter int WORDS_PER_LINE   = TILE_PER_LINE / TILES_PER_WORD,
  parameter int FBUFF_ADDR_WIDTH = 12,
  parameter int LBUFF_ADDR_WIDTH = $clog2(TILE_PER_LINE - 1),
  parameter int ROW_WIDTH        = $clog2(TILE_ROWS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        line_req_i,
  input  logic [ROW_WIDTH-1:0]        row_i,
  output logic                        fbuff_en_o,
  output logic [FBUFF_ADDR_WIDTH-1:0] fbuff_addr_o,
  input  logic [FBUFF_DATA_WIDTH-1:0] fbuff_dout_i,
  output logic [LBUFF_ADDR_WIDTH-1:0] lbuff_addr_o,
  output logic [COLR_PXL_WIDTH-1:0]   lbuff_din_o,
  output logic [1:0]                  lbuff_we_o,
  output logic                        rd_sel_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        overrun_o,
  output logic                        range_err_o
);

  localparam int WIDX_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int TIDX_W = (TILES_PER_WORD > 1) ? $clog2(TILES_PER_WORD) : 1;

  localparam logic [WIDX_W-1:0]           LAST_WORD = WIDX_W'(WORDS_PER_LINE - 1);
  localparam logic [TIDX_W-1:0]           LAST_TILE = TIDX_W'(TILES_PER_WORD - 1);
  localparam logic [ROW_WIDTH:0]          ROWS_LIM  = (ROW_WIDTH + 1)'(TILE_ROWS);
  localparam logic [FBUFF_ADDR_WIDTH-1:0] WPL_A     = FBUFF_ADDR_WIDTH'(WORDS_PER_LINE);
  localparam logic [LBUFF_ADDR_WIDTH-1:0] TPW_L     = LBUFF_ADDR_WIDTH'(TILES_PER_WORD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t                      state;
  state_t                      state_nxt;
  logic                        wr_sel;
  logic [ROW_WIDTH-1:0]        row_r;
  logic [WIDX_W-1:0]           word_idx;
  logic [TIDX_W-1:0]           tile_idx;
  logic [FBUFF_DATA_WIDTH-1:0] word_r;
  logic [COLR_PXL_WIDTH-1:0]   tile_dat;
  logic                        row_ok;
  logic                        tile_last;
  logic                        word_last;
  logic                        accept;

  // Extra MSB keeps the compare correct even when TILE_ROWS is a power of two.
  assign row_ok    = ({1'b0, row_i} < ROWS_LIM);
  assign tile_last = (tile_idx == LAST_TILE);
  assign word_last = (word_idx == LAST_WORD);
  assign accept    = (state == IDLE) && line_req_i && row_ok;

  assign busy_o   = (state != IDLE);
  assign rd_sel_o = ~wr_sel;

  // Tile 0 sits in the word LSBs; constant-index slices keep the mux plain.
  always_comb begin
    tile_dat = '0;
    for (int t = 0; t < TILES_PER_WORD; t++) begin
      if (tile_idx == TIDX_W'(t)) begin
        tile_dat = word_r[t*COLR_PXL_WIDTH +: COLR_PXL_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fbuff_en_o   = 1'b0;
    fbuff_addr_o = '0;
    lbuff_we_o   = 2'b00;
    lbuff_addr_o = '0;
    lbuff_din_o  = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        fbuff_en_o   = 1'b1;
        fbuff_addr_o = FBUFF_ADDR_WIDTH'(row_r) * WPL_A + FBUFF_ADDR_WIDTH'(word_idx);
        state_nxt    = LOAD;
      end
      LOAD: begin
        state_nxt = WRITE;
      end
      WRITE: begin
        lbuff_we_o   = wr_sel ? 2'b10 : 2'b01;
        lbuff_addr_o = LBUFF_ADDR_WIDTH'(word_idx) * TPW_L + LBUFF_ADDR_WIDTH'(tile_idx);
        lbuff_din_o  = tile_dat;
        if (tile_last) begin
          state_nxt = word_last ? IDLE : FETCH;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sel      <= 1'b0;
      row_r       <= '0;
      word_idx    <= '0;
      tile_idx    <= '0;
      word_r      <= '0;
      done_o      <= 1'b0;
      overrun_o   <= 1'b0;
      range_err_o <= 1'b0;
    end else begin
      done_o <= (state == WRITE) && tile_last && word_last;

      // Error flags are independent: a bad row arriving mid-fill sets both.
      if (line_req_i && !row_ok) begin
        range_err_o <= 1'b1;
      end
      if (line_req_i && (state != IDLE)) begin
        overrun_o <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            wr_sel   <= ~wr_sel;
            row_r    <= row_i;
            word_idx <= '0;
          end
        end
        LOAD: begin
          word_r   <= fbuff_dout_i;
          tile_idx <= '0;
        end
        WRITE: begin
          if (tile_last) begin
            tile_idx <= '0;
            if (!word_last) begin
              word_idx <= word_idx + 1'b1;
            end
          end else begin
            tile_idx <= tile_idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/lbuff_fill_ctrl.md
Name: lbuff_fill_ctrl

Overview:
Line-buffer fill controller, directly upstream of the two ping-pong line-buffer BRAMs (COLR_PXL_WIDTH x TILE_PER_LINE each).
- On a line request from the VGA timing logic it reads one tile row from the frame buffer (FBUFF_DATA_WIDTH-bit words, one tile per COLR_PXL_WIDTH slice).
- It unpacks each word and writes the tiles into the currently inactive line buffer.
- It owns the ping-pong select so the display side always reads the buffer not being written.

Parameters:
- COLR_PXL_WIDTH, 12, bits per tile colour entry.
- WIDTH_PX, 640, active pixels per line.
- TILE_WIDTH, 4, pixels per tile horizontally.
- TILE_PER_LINE, WIDTH_PX/TILE_WIDTH (160), tiles per line buffer.
- TILE_ROWS, 120, tile rows per frame.
- FBUFF_DATA_WIDTH, 60, frame-buffer word width.
- TILES_PER_WORD, FBUFF_DATA_WIDTH/COLR_PXL_WIDTH (5), tiles packed per word.
- WORDS_PER_LINE, TILE_PER_LINE/TILES_PER_WORD (32), frame-buffer words per tile row.
- FBUFF_ADDR_WIDTH, 12, frame-buffer address width.
- LBUFF_ADDR_WIDTH, $clog2(TILE_PER_LINE-1) (8), line-buffer address width.
- ROW_WIDTH, $clog2(TILE_ROWS) (7), row index width.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- line_req_i  in  1  single-cycle request to fill one tile row.
- row_i  in  ROW_WIDTH  tile row to fetch; sampled with line_req_i.
- fbuff_en_o  out  1  frame-buffer read enable.
- fbuff_addr_o  out  FBUFF_ADDR_WIDTH  frame-buffer read address.
- fbuff_dout_i  in  FBUFF_DATA_WIDTH  frame-buffer read data; valid 1 cycle after fbuff_en_o.
- lbuff_addr_o  out  LBUFF_ADDR_WIDTH  line-buffer write address.
- lbuff_din_o  out  COLR_PXL_WIDTH  line-buffer write data.
- lbuff_we_o  out  2  one-hot write enable; bit = buffer being filled.
- rd_sel_o  out  1  buffer index the display reads (always ~wr_sel).
- busy_o  out  1  high while a fill is in progress.
- done_o  out  1  single-cycle pulse when a fill completes.
- overrun_o  out  1  sticky: request arrived while busy.
- range_err_o  out  1  sticky: request with row_i >= TILE_ROWS.

Behaviour:
- Reset (async assert, release on next clk edge):
  - state IDLE, internal wr_sel=0, rd_sel_o=1.
  - All other outputs 0; sticky flags cleared.
  - Reset mid-fill abandons the partial line; no done_o.
- FSM states: IDLE, FETCH, LOAD, WRITE.
- IDLE, line_req_i=1, row_i < TILE_ROWS:
  - toggle wr_sel (rd_sel_o flips the following cycle);
  - latch row, word_idx=0, busy_o=1, go to FETCH.
- IDLE, row_i >= TILE_ROWS: range_err_o set, no toggle, stay IDLE.
- FETCH (1 cycle): fbuff_en_o=1, fbuff_addr_o=row*WORDS_PER_LINE+word_idx → LOAD.
- LOAD (1 cycle): register fbuff_dout_i into word_r, tile_idx=0 → WRITE.
- WRITE (TILES_PER_WORD cycles): one tile per cycle.
  - lbuff_we_o[wr_sel]=1, lbuff_din_o=word_r[tile_idx*COLR_PXL_WIDTH +: COLR_PXL_WIDTH] (tile 0 = LSBs).
  - lbuff_addr_o=word_idx*TILES_PER_WORD+tile_idx.
  - After tile_idx=TILES_PER_WORD-1: if word_idx<WORDS_PER_LINE-1, increment word_idx → FETCH; else → IDLE, done_o=1 for one cycle, busy_o=0.
- Timing: 7 cycles per word; req at edge 0 → first fbuff_en_o cycle 1, first write cycle 3, last write cycle 224, done_o cycle 225.
- Default outputs: lbuff_we_o=0 and fbuff_en_o=0 outside WRITE/FETCH respectively.
- line_req_i while busy_o=1 (including the done_o cycle excluded: done cycle is IDLE and accepts):
  - overrun_o set; request dropped; fill continues unaffected; no toggle.
- Simultaneous line_req_i with out-of-range row while busy: both sticky flags set.
- Addresses never exceed TILE_PER_LINE-1 or TILE_ROWS*WORDS_PER_LINE-1; all counters wrap only via explicit reset to 0.

Test Plan:
- Reset, frame buffer word(r,w) = 5 tiles valued {r,w,t}, req row 0 → 160 writes to buffer 1 (we=2'b10), addr 0..159 in order with matching data, done_o at cycle 225, rd_sel_o=0.
- Two back-to-back fills (row 3 then row 4, second req after done) → second fill writes buffer 0, rd_sel_o returns to 1, fbuff_addr 96..127 then 128..159.
- Req row 119 → fbuff_addr 3808..3839, last write addr 159 = tile 4 of word 3839.
- Req at cycle 50 of an active fill → overrun_o=1 sticky, fill completes unchanged, wr_sel not toggled.
- Req row 120 from IDLE → range_err_o=1, no fbuff_en_o, no lbuff_we_o, rd_sel_o unchanged.
- Assert rst at cycle 100 of a fill → all outputs 0, rd_sel_o=1 immediately, no done_o; new req row 2 then completes normally into buffer 1.
